serial_adder: RTL and testbench

- Bit-serial N-bit adder. Operands are accepted on a valid/ready handshake and shifted LSB-first through one full-adder slice with a registered carry.
- The sum is assembled in a shift register and presented on an output valid/ready handshake.
- Sits upstream of the full-adder slice, feeding it one bit pair per clock and consuming its sum/carry.
- Trades WIDTH cycles of latency for a single adder cell.

---
 rtl/serial_adder.sv | 131 +++++++++++++
 tb/tb_serial_adder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder built around one full-adder cell.
// Operands are accepted on an in_valid/in_ready handshake. They are then
// shifted LSB-first through the cell, which has a registered carry. The result
// is offered on an out_valid/out_ready handshake.
// Optional feature: define SERIAL_ADDER_SUB_EN to add a 'sub' input that turns
// the operation into a - b (two's complement; cout=1 means no borrow).
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;   // partial sum being assembled
  logic [WIDTH-1:0] sum_q, sum_d;         // last completed result, held
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Operand values captured at accept (b inverted and carry forced for subtract)
  logic [WIDTH-1:0] b_load;
  logic             c_load;

`ifdef SERIAL_ADDER_SUB_EN
  assign b_load = sub ? ~b : b;
  assign c_load = sub ? 1'b1 : cin;
`else
  assign b_load = b;
  assign c_load = cin;
`endif

  // One full-adder slice working on the current LSBs
  logic bit_s;
  logic bit_c;
  assign bit_s = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
  assign bit_c = (a_sh_q[0] & b_sh_q[0]) | ((a_sh_q[0] ^ b_sh_q[0]) & c_q);

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;

  // Next-state and datapath update; result registers only move at completion
  always_comb begin
    // NOTE: every signal gets a default here first so no path leaves it unassigned and infers a latch.
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    sum_d    = sum_q;
    c_d      = c_q;
    cout_d   = cout_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b_load;
          c_d     = c_load;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
        sum_sh_d = {bit_s, sum_sh_q[WIDTH-1:1]};
        c_d      = bit_c;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          sum_d   = {bit_s, sum_sh_q[WIDTH-1:1]};
          cout_d  = bit_c;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: all state, including the datapath shift registers, is reset so an aborted operation leaves nothing behind.
    if (rst) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      sum_q    <= '0;
      c_q      <= 1'b0;
      cout_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      sum_q    <= sum_d;
      c_q      <= c_d;
      cout_q   <= cout_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8). A transaction-level model
// computes each result with plain arithmetic and tracks handshake timing with
// a latency countdown. A negedge compare process checks all outputs every
// cycle. Directed cases add literal expectations, and a random phase follows.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: full (W+1)-bit result, cout in the top bit
  function automatic logic [W:0] ref_result(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                            input logic rc, input logic rs);
    logic [W:0] r;
`ifdef SERIAL_ADDER_SUB_EN
    if (rs) r = {1'b0, ra} + {1'b0, ~rb} + (W+1)'(1);
    else    r = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
`else
    r = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
    if (rs) r = r;
`endif
    return r;
  endfunction

  // Transaction-level model: idle -> W cycles busy -> result offered
  logic         m_in_ready;
  logic         m_out_valid;
  logic [W-1:0] m_sum;
  logic         m_cout;
  logic [W:0]   m_res;
  int           m_left;
  logic         chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_in_ready  <= 1'b1;
      m_out_valid <= 1'b0;
      m_sum       <= '0;
      m_cout      <= 1'b0;
      m_left      <= 0;
    end else if (m_in_ready && in_valid) begin
      m_res      <= ref_result(a, b, cin, sub);
      m_left     <= W;
      m_in_ready <= 1'b0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_out_valid <= 1'b1;
        m_sum       <= m_res[W-1:0];
        m_cout      <= m_res[W];
      end
    end else if (m_out_valid && out_ready) begin
      m_out_valid <= 1'b0;
      m_in_ready  <= 1'b1;
    end
  end

  // Per-cycle compare against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready",  {31'd0, in_ready},  {31'd0, m_in_ready});
      check("out_valid", {31'd0, out_valid}, {31'd0, m_out_valid});
      check("sum",       {24'd0, sum},       {24'd0, m_sum});
      check("cout",      {31'd0, cout},      {31'd0, m_cout});
    end
  end

  // Present operands and hold in_valid until the accepting edge has passed
  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic tc, input logic ts);
    int n;
    a = ta; b = tb_v; cin = tc; sub = ts; in_valid = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 200) begin
      @(posedge clk); #2; n++;
    end
    if (n >= 200) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: in_ready never rose");
    end
    @(posedge clk); #2;
    in_valid = 1'b0;
  endtask

  // Wait for out_valid from just after the accept edge; latency must equal W
  task automatic wait_done(input string name, input logic [W-1:0] es, input logic ec);
    int lat;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #2; lat++;
    end
    check({name, "_latency"}, lat, W);
    check({name, "_sum"}, {24'd0, sum}, {24'd0, es});
    check({name, "_cout"}, {31'd0, cout}, {31'd0, ec});
  endtask

  task automatic run_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic tc, input logic ts, input logic [W-1:0] es, input logic ec);
    start_op(ta, tb_v, tc, ts);
    wait_done(name, es, ec);
    @(posedge clk); #2;   // handshake edge (out_ready high)
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    @(posedge clk); #2;
    chk_en = 1'b1;
    @(posedge clk); #2;
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_sum",       {24'd0, sum},       32'd0);
    check("rst_cout",      {31'd0, cout},      32'd0);
    rst = 1'b0;
    @(posedge clk); #2;

    // Basic add and carry-out cases
    run_op("basic", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0);
    check("basic_back_idle", {31'd0, in_ready}, 32'd1);
    run_op("ovf1", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
    run_op("ovf2", 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1);

    // Backpressure: result held, new operands refused while DONE
    out_ready = 1'b0;
    start_op(8'h33, 8'h44, 1'b0, 1'b0);
    wait_done("bp", 8'h77, 1'b0);
    a = 8'h22; b = 8'h11; cin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #2;
      check("bp_hold_sum",   {24'd0, sum},       32'h77);
      check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      check("bp_in_ready",   {31'd0, in_ready},  32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #2;
    check("bp_released", {31'd0, out_valid}, 32'd0);
    start_op(8'h22, 8'h11, 1'b0, 1'b0);
    wait_done("bp_next", 8'h33, 1'b0);
    @(posedge clk); #2;

    // Reset during SHIFT: aborts, nothing partial is shown
    start_op(8'hAA, 8'h55, 1'b0, 1'b0);
    repeat (3) begin @(posedge clk); #2; end
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_sum",       {24'd0, sum},       32'd0);
    check("midrst_cout",      {31'd0, cout},      32'd0);
    check("midrst_in_ready",  {31'd0, in_ready},  32'd1);
    run_op("after_rst", 8'h03, 8'h04, 1'b0, 1'b0, 8'h07, 1'b0);

    // Operand inputs change after acceptance
    start_op(8'h10, 8'h20, 1'b0, 1'b0);
    a = 8'hFF; b = 8'hFF; cin = 1'b1;
    wait_done("opchg", 8'h30, 1'b0);
    @(posedge clk); #2;

`ifdef SERIAL_ADDER_SUB_EN
    run_op("sub_borrow", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0);
    run_op("sub_ok",     8'h07, 8'h05, 1'b1, 1'b1, 8'h02, 1'b1);
    run_op("sub0_add",   8'h07, 8'h05, 1'b1, 1'b0, 8'h0D, 1'b0);
`endif

    // Random traffic with random backpressure and occasional reset
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #2;
      in_valid  = ($urandom_range(0, 2) != 0);
      a         = W'($urandom);
      b         = W'($urandom);
      cin       = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
      sub       = 1'($urandom);
`endif
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 199) == 0);
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2 * W + 4) begin @(posedge clk); #2; end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
